// File: rtl/onchip_mem_loader.sv
// onchip_mem_loader: packs a byte stream into 32-bit Avalon-MM RAM writes; define LOADER_VERIFY_EN for a readback verify pass.
module onchip_mem_loader #(
   parameter int ADDR_W = 10,
   parameter int LEN_W  = 12,
   parameter int CSUM_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [LEN_W-1:0]  byte_len,
   input  logic              abort,
   input  logic              s_valid,
   input  logic [7:0]        s_data,
   output logic              s_ready,
   output logic [ADDR_W-1:0] mem_address,
   output logic [3:0]        mem_byteenable,
   output logic              mem_chipselect,
   output logic              mem_write,
   output logic [31:0]       mem_writedata,
   output logic              mem_clken,
   input  logic [31:0]       mem_readdata,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W-1:0] err_addr,
   output logic [CSUM_W-1:0] checksum
);
`ifdef LOADER_VERIFY_EN
   typedef enum logic [2:0] {IDLE, FILL, WRITE, VRD, VCMP, DONE} state_t;
`else
   typedef enum logic [2:0] {IDLE, FILL, WRITE, DONE} state_t;
`endif
   state_t state, state_nx;
   logic [ADDR_W-1:0] addr;
   logic [LEN_W-1:0] rem;
   logic [1:0] lane;
   logic [3:0] be;
   logic [31:0] word;
   logic go, acc, wr, rd, last_wr;
`ifdef LOADER_VERIFY_EN
   logic [ADDR_W-1:0] base_q;
   logic [LEN_W-1:0] len_q, vrem;
   logic [CSUM_W-1:0] wsum, rsum, rsum_nx, lsum, sum_rd;
   logic [CSUM_W-1:0] sums [2**ADDR_W];
   logic [3:0] vmask;
   logic vcmp, hit;
   assign rd = state == VRD && !abort;
   assign vcmp = state == VCMP && !abort;
   // lanes enabled for the word under readback follow from the bytes still to verify
   assign vmask = vrem > LEN_W'(3) ? 4'hF : 4'hF >> (3'd4 - {1'b0, vrem[1:0]});
   assign rsum_nx = rsum + lsum;
   always_comb begin
      lsum = '0;
      for (int i = 0; i < 4; i++)
         if (vmask[i]) lsum = lsum + CSUM_W'(mem_readdata[8*i +: 8]);
   end
   always_ff @(posedge clk) begin
      if (wr) sums[addr] <= wsum;
      if (rd) sum_rd <= sums[addr];
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         base_q <= '0;
         len_q <= '0;
         vrem <= '0;
         wsum <= '0;
         rsum <= '0;
         hit <= 1'b0;
         err <= 1'b0;
         err_addr <= '0;
      end else begin
         if (go) begin
            base_q <= base_addr;
            len_q <= byte_len;
            wsum <= '0;
            hit <= 1'b0;
            err <= 1'b0;
            err_addr <= '0;
         end
         if (acc) wsum <= wsum + CSUM_W'(s_data);
         if (wr) wsum <= '0;
         if (last_wr) begin
            vrem <= len_q;
            rsum <= '0;
         end
         if (vcmp) begin
            rsum <= rsum_nx;
            vrem <= vrem - LEN_W'(4);
            if (!hit && lsum != sum_rd) begin
               hit <= 1'b1;
               err_addr <= addr;
            end
            if (vrem <= LEN_W'(4)) err <= rsum_nx != checksum;
         end
      end
   end
`else
   logic unused_rd;
   assign rd = 1'b0;
   assign err = 1'b0;
   assign err_addr = '0;
   assign unused_rd = ^mem_readdata;
`endif
   assign go = state == IDLE && start && !abort;
   assign s_ready = state == FILL && !abort;
   assign acc = s_valid && s_ready;
   assign wr = state == WRITE && !abort;
   assign last_wr = wr && rem == '0;
   assign mem_write = wr;
   assign mem_chipselect = wr || rd;
   assign mem_clken = wr || rd;
   assign mem_address = addr;
   assign mem_writedata = word;
   assign mem_byteenable = wr ? be : {4{rd}};
   assign busy = state != IDLE && state != DONE;
   assign done = state == DONE && !abort;
   always_comb begin
      state_nx = state;
      if (abort) state_nx = IDLE;
      else
         case (state)
            IDLE:  state_nx = !start ? IDLE : byte_len == '0 ? DONE : FILL;
            FILL:  state_nx = acc && (lane == 2'd3 || rem == LEN_W'(1)) ? WRITE : FILL;
`ifdef LOADER_VERIFY_EN
            WRITE: state_nx = last_wr ? VRD : FILL;
            VRD:   state_nx = VCMP;
            VCMP:  state_nx = vrem > LEN_W'(4) ? VRD : DONE;
`else
            WRITE: state_nx = last_wr ? DONE : FILL;
`endif
            default: state_nx = IDLE;
         endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         addr <= '0;
         rem <= '0;
         lane <= '0;
         be <= '0;
         word <= '0;
         checksum <= '0;
      end else begin
         state <= state_nx;
         if (go) begin
            addr <= base_addr;
            rem <= byte_len;
            lane <= '0;
            be <= '0;
            word <= '0;
            checksum <= '0;
         end
         if (acc) begin
            word[8*lane +: 8] <= s_data;
            be[lane] <= 1'b1;
            lane <= lane + 2'd1;
            rem <= rem - 1'b1;
            checksum <= checksum + CSUM_W'(s_data);
         end
         if (wr) begin
            addr <= addr + 1'b1;
            lane <= '0;
            be <= '0;
            word <= '0;
         end
`ifdef LOADER_VERIFY_EN
         if (last_wr) addr <= base_q;
         if (vcmp) addr <= addr + 1'b1;
`endif
      end
   end
endmodule

// File: tb/tb_onchip_mem_loader.sv
// tb_onchip_mem_loader: randomized loads checked against a word-packing reference model.
module tb_onchip_mem_loader;
   localparam int ADDR_W = 10;
   localparam int LEN_W  = 12;
   localparam int CSUM_W = 16;
   logic clk = 1'b0;
   logic reset, start, abort, s_valid, s_ready;
   logic [ADDR_W-1:0] base_addr, mem_address, err_addr;
   logic [LEN_W-1:0] byte_len;
   logic [7:0] s_data;
   logic [3:0] mem_byteenable;
   logic mem_chipselect, mem_write, mem_clken, busy, done, err;
   logic [31:0] mem_writedata, mem_readdata;
   logic [CSUM_W-1:0] checksum;
   int n_checks = 0;
   int n_fail = 0;
   int cyc = 0;
   int done_cnt = 0;
   int done_cyc = 0;
   int rdy_cnt = 0;
   int cs_cnt = 0;
   logic [ADDR_W-1:0] got_a [$];
   logic [31:0] got_d [$];
   logic [3:0] got_be [$];
   int got_t [$];
   logic [7:0] stim [$];

   always #5 clk = ~clk;

   onchip_mem_loader #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .CSUM_W(CSUM_W)) dut (
      .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .byte_len(byte_len),
      .abort(abort), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
      .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_chipselect(mem_chipselect),
      .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_clken(mem_clken),
      .mem_readdata(mem_readdata), .busy(busy), .done(done), .err(err), .err_addr(err_addr),
      .checksum(checksum)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s got=0x%0h want=0x%0h", tag, got, want);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!reset) begin
         check("cs_is_wr", mem_chipselect, mem_write);
         check("clken_is_wr", mem_clken, mem_write);
         if (mem_write) begin
            check("rdy_in_wr", s_ready, 1'b0);
            got_a.push_back(mem_address);
            got_d.push_back(mem_writedata);
            got_be.push_back(mem_byteenable);
            got_t.push_back(cyc);
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (s_ready) rdy_cnt++;
         if (mem_chipselect) cs_cnt++;
      end
   end

   task automatic seq(input int first, input int step, input int len);
      stim.delete();
      for (int i = 0; i < len; i++) stim.push_back(8'(first + step * i));
   endtask

   task automatic rand_stim(input int len);
      stim.delete();
      for (int i = 0; i < len; i++) stim.push_back(8'($urandom));
   endtask

   task automatic do_load(input int base, input int len, input int gap, input int abort_at, input bit poke);
      int idx, n, t0, nw, cs;
      logic [31:0] d;
      logic [3:0] be;
      got_a.delete();
      got_d.delete();
      got_be.delete();
      got_t.delete();
      done_cnt = 0;
      @(posedge clk);
      #1;
      start = 1'b1;
      base_addr = ADDR_W'(base);
      byte_len = LEN_W'(len);
      @(posedge clk);
      #1;
      start = 1'b0;
      t0 = cyc;
      idx = 0;
      n = 0;
      check("busy_start", busy, 1'b1);
      while (done_cnt == 0 && n < 40 * len + 40) begin
         s_valid = idx < len && $urandom_range(99) >= gap;
         s_data = s_valid ? stim[idx] : 8'($urandom);
         abort = idx == abort_at;
         start = poke && idx == 1;
         if (start) begin
            base_addr = ADDR_W'($urandom);
            byte_len = 3;
         end
         @(negedge clk);
         if (abort) check("abort_rdy", s_ready, 1'b0);
         if (s_valid && s_ready) idx++;
         @(posedge clk);
         #1;
         n++;
         if (abort) begin
            abort = 1'b0;
            check("abort_busy", busy, 1'b0);
            break;
         end
      end
      s_valid = 1'b0;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      if (abort_at >= 0) begin
         check("abort_nodone", done_cnt, 0);
         check("abort_nowr", got_a.size(), 0);
      end else begin
         nw = (len + 3) / 4;
         cs = 0;
         check("done_once", done_cnt, 1);
         check("busy_end", busy, 1'b0);
         check("n_writes", got_a.size(), nw);
         for (int w = 0; w < nw && w < got_a.size(); w++) begin
            d = '0;
            be = '0;
            for (int k = 0; k < 4; k++)
               if (4 * w + k < len) begin
                  d[8*k +: 8] = stim[4*w+k];
                  be[k] = 1'b1;
               end
            check("wr_addr", got_a[w], (base + w) % 1024);
            check("wr_data", got_d[w], d);
            check("wr_be", got_be[w], be);
            if (gap == 0) check("wr_time", got_t[w] - t0, (4 * w + 4 < len ? 4 * w + 4 : len) + w);
         end
         foreach (stim[i]) cs += stim[i];
         check("checksum", checksum, cs % 65536);
         if (gap == 0) check("done_time", done_cyc - t0, len + nw);
      end
   endtask

   initial begin
      int len, base;
      reset = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      s_valid = 1'b0;
      s_data = '0;
      base_addr = '0;
      byte_len = '0;
      mem_readdata = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_rdy", s_ready, 1'b0);
      check("rst_addr", mem_address, 0);
      check("rst_be", mem_byteenable, 0);
      check("rst_cs", mem_chipselect, 1'b0);
      check("rst_wr", mem_write, 1'b0);
      check("rst_wdata", mem_writedata, 0);
      check("rst_clken", mem_clken, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_err", err, 1'b0);
      check("rst_err_addr", err_addr, 0);
      check("rst_csum", checksum, 0);
      reset = 1'b0;
      seq(1, 1, 8);
      do_load(0, 8, 0, -1, 1'b0);
      seq(8'hAA, 8'h11, 5);
      do_load(1023, 5, 0, -1, 1'b0);
      rdy_cnt = 0;
      cs_cnt = 0;
      done_cnt = 0;
      @(posedge clk);
      #1;
      start = 1'b1;
      base_addr = 10'h123;
      byte_len = '0;
      @(negedge clk);
      check("len0_pre", done, 1'b0);
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      check("len0_done", done, 1'b1);
      check("len0_busy", busy, 1'b0);
      @(negedge clk);
      check("len0_after", done, 1'b0);
      check("len0_no_cs", cs_cnt, 0);
      check("len0_no_rdy", rdy_cnt, 0);
      seq(1, 1, 8);
      do_load(0, 8, 0, 2, 1'b0);
      do_load(0, 8, 0, -1, 1'b0);
      do_load(0, 8, 40, -1, 1'b1);
      rdy_cnt = 0;
      cs_cnt = 0;
      done_cnt = 0;
      @(posedge clk);
      #1;
      start = 1'b1;
      abort = 1'b1;
      base_addr = 10'd5;
      byte_len = 12'd4;
      s_valid = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      abort = 1'b0;
      check("sa_busy", busy, 1'b0);
      repeat (6) @(posedge clk);
      #1;
      s_valid = 1'b0;
      check("sa_nodone", done_cnt, 0);
      check("sa_nordy", rdy_cnt, 0);
      check("sa_nocs", cs_cnt, 0);
      @(posedge clk);
      #1;
      start = 1'b1;
      base_addr = 10'd7;
      byte_len = 12'd12;
      @(posedge clk);
      #1;
      start = 1'b0;
      s_valid = 1'b1;
      s_data = 8'h5A;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      s_valid = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      check("midrst_busy", busy, 1'b0);
      check("midrst_csum", checksum, 0);
      check("midrst_rdy", s_ready, 1'b0);
      for (int r = 0; r < 8; r++) begin
         len = $urandom_range(24, 1);
         base = r < 2 ? 1020 + r : $urandom_range(1023);
         rand_stim(len);
         do_load(base, len, r % 2 == 1 ? $urandom_range(60) : 0, -1, r == 3);
      end
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
